// File: rtl/stream_blur.sv
// stream_blur: 3x3 Gaussian/mean/identity blur over a raster pixel stream, two line buffers of storage.
// Latency: output k registers the cycle after input k+WIDTH+1 is accepted; WIDTH+1 drain beats close the frame.
// Backpressure: in_ready drops while an output beat is stalled; a stalled output beat holds its data and last flag.
module stream_blur #(
    parameter int WIDTH    = 350,
    parameter int HEIGHT   = 350,
    parameter int CHANNELS = 3,
    parameter int PIX_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                kernel_type,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*PIX_W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*PIX_W-1:0] out_data,
    output logic                      out_last,
    output logic                      frame_done
);
    localparam int DW    = CHANNELS * PIX_W;
    localparam int DEPTH = 2 * WIDTH + 3;
    localparam int ACC_W = PIX_W + 5;
    localparam int CW    = $clog2(WIDTH);
    localparam int RW    = $clog2(HEIGHT);
    localparam int NW    = $clog2(WIDTH * HEIGHT);

    typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic            ready_en;
    logic [1:0]      kern;
    logic [NW-1:0]   in_cnt;
    logic [CW-1:0]   o_col;
    logic [RW-1:0]   o_row;
    logic [DW-1:0]   sr  [0:DEPTH-2];
    logic [DW-1:0]   win [0:DEPTH-1];
    logic [DW-1:0]   new_pix;
    logic [DW-1:0]   blur_dat;
    logic [ACC_W-1:0] acc;
    logic [4:0]      div;
    logic [2:0]      wt;
    logic            out_free, in_fire, drain_step, produce;

    function automatic logic [2:0] tap_weight(input logic [1:0] k, input int di, input int dj);
        logic [2:0] w;
        case (k)
            2'd0:    w = 3'((di == 0 ? 2 : 1) * (dj == 0 ? 2 : 1));
            2'd1:    w = 3'd1;
            default: w = (di == 0 && dj == 0) ? 3'd1 : 3'd0;
        endcase
        return w;
    endfunction

    assign out_free   = !out_valid || out_ready;
    assign in_ready   = ready_en && out_free && (state == IDLE || state == FILL || state == RUN);
    assign in_fire    = in_valid && in_ready;
    // out_last only rides on a valid beat, so it marks that the final output is already in the register
    assign drain_step = (state == DRAIN) && out_free && !out_last;
    assign produce    = (in_fire && state == RUN) || drain_step;
    assign new_pix    = in_fire ? in_data : '0;

    // win[0] is the pixel arriving this cycle; win[i] is the pixel accepted i beats earlier
    always_comb begin
        win[0] = new_pix;
        for (int i = 1; i < DEPTH; i++) begin
            win[i] = sr[i-1];
        end
    end

    always_comb begin
        blur_dat = '0;
        acc      = '0;
        div      = '0;
        wt       = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            acc = '0;
            div = '0;
            for (int di = -1; di <= 1; di++) begin
                for (int dj = -1; dj <= 1; dj++) begin
                    wt = tap_weight(kern, di, dj);
                    if (int'(o_row) + di < 0 || int'(o_row) + di >= HEIGHT ||
                        int'(o_col) + dj < 0 || int'(o_col) + dj >= WIDTH) begin
                        wt = '0;
                    end
                    acc = acc + ACC_W'(wt) *
                          ACC_W'(win[WIDTH + 1 - di * WIDTH - dj][ch*PIX_W +: PIX_W]);
                    div = div + 5'(wt);
                end
            end
            blur_dat[ch*PIX_W +: PIX_W] = PIX_W'((acc + ACC_W'(div >> 1)) / ACC_W'(div));
        end
    end

    // Pure delay line: stale contents only ever land on out-of-frame taps, which carry zero weight
    always_ff @(posedge clk) begin
        if (in_fire || drain_step) begin
            sr[0] <= new_pix;
            for (int i = 1; i < DEPTH - 1; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ready_en   <= 1'b0;
            kern       <= '0;
            in_cnt     <= '0;
            o_col      <= '0;
            o_row      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            frame_done <= 1'b0;
            if (produce) begin
                out_valid <= 1'b1;
                out_data  <= blur_dat;
                out_last  <= (o_row == RW'(HEIGHT - 1)) && (o_col == CW'(WIDTH - 1));
                if (o_col == CW'(WIDTH - 1)) begin
                    o_col <= '0;
                    o_row <= (o_row == RW'(HEIGHT - 1)) ? '0 : o_row + 1'b1;
                end else begin
                    o_col <= o_col + 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                IDLE: if (in_fire) begin
                    kern   <= kernel_type;
                    in_cnt <= NW'(1);
                    state  <= FILL;
                end
                FILL: if (in_fire) begin
                    in_cnt <= in_cnt + 1'b1;
                    if (in_cnt == NW'(WIDTH)) state <= RUN;
                end
                RUN: if (in_fire) begin
                    in_cnt <= in_cnt + 1'b1;
                    if (in_cnt == NW'(WIDTH * HEIGHT - 1)) begin
                        in_cnt <= '0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: if (out_valid && out_ready && out_last) begin
                    frame_done <= 1'b1;
                    state      <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_blur.sv
// Directed and randomised frames through a 4x4 stream_blur, checked against a scoreboard fed by a reference model.
module tb_stream_blur;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  kernel_type;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_last;
    logic        frame_done;

    always #5 clk = ~clk;

    stream_blur #(.WIDTH(W), .HEIGHT(H), .CHANNELS(3), .PIX_W(8)) dut (
        .clk(clk), .reset(reset), .kernel_type(kernel_type),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [23:0] dat;
        logic        last;
    } exp_t;

    exp_t        q [$];
    exp_t        e;
    logic [23:0] cur [N];
    logic [23:0] cap [256];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_out = 0;
    int          n_done = 0;
    int          frame_base = 0;
    int          first_ov = -1;
    bit          seen_ov = 1'b0;
    bit          rnd_out = 1'b0;
    int          gk [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(input int kt, input int r, input int c);
        logic [23:0] res;
        int acc;
        int dv;
        int w;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            acc = 0;
            dv  = 0;
            for (int rr = r - 1; rr <= r + 1; rr++) begin
                for (int cc = c - 1; cc <= c + 1; cc++) begin
                    if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                        if (kt == 0)      w = gk[rr-r+1][cc-c+1];
                        else if (kt == 1) w = 1;
                        else              w = (rr == r && cc == c) ? 1 : 0;
                        acc += w * int'(cur[rr*W+cc][ch*8 +: 8]);
                        dv  += w;
                    end
                end
            end
            res[ch*8 +: 8] = 8'((acc + dv / 2) / dv);
        end
        return res;
    endfunction

    function automatic logic [23:0] capd(input int idx);
        return cap[(frame_base + idx) & 255];
    endfunction

    // Output monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                chk("out_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.dat));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
                cap[n_out & 255] = out_data;
                n_out++;
            end
            if (frame_done) n_done++;
        end
    end

    task automatic push_frame(input int kt);
        exp_t t;
        for (int k = 0; k < N; k++) begin
            t.dat  = model_pix(kt, k / W, k % W);
            t.last = (k == N - 1);
            q.push_back(t);
        end
    endtask

    task automatic drive_beats(input int n, input int kt, input bit rnd_in, input bit tog, input string tag);
        int i;
        int guard;
        i = 0;
        guard = 0;
        seen_ov = 1'b0;
        first_ov = -1;
        while (i < n && guard < 1000) begin
            in_valid    = rnd_in ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data     = cur[i];
            kernel_type = (tog && i > 0) ? 2'($urandom_range(0, 3)) : 2'(kt);
            out_ready   = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (!seen_ov && out_valid) begin
                seen_ov  = 1'b1;
                first_ov = i;
            end
            if (in_valid && in_ready) i++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        chk({tag, "_beats_accepted"}, 32'(i), 32'(n));
    endtask

    task automatic run_frame(input int kt, input bit rnd_in, input bit tog, input string tag);
        int base_out;
        int base_done;
        int guard;
        base_out  = n_out;
        base_done = n_done;
        push_frame(kt);
        drive_beats(N, kt, rnd_in, tog, tag);
        guard = 0;
        while (n_done == base_done && guard < 1000) begin
            out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            guard++;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, 32'(n_done - base_done), 32'd1);
        chk({tag, "_out_count"}, 32'(n_out - base_out), 32'(N));
        chk({tag, "_queue_left"}, 32'(q.size()), 32'd0);
        frame_base = base_out;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        kernel_type = 2'd0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_release_cycle", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);

        for (int i = 0; i < N; i++) cur[i] = {3{8'd100}};
        run_frame(0, 1'b0, 1'b0, "const_gauss");
        run_frame(1, 1'b0, 1'b0, "const_mean");

        for (int i = 0; i < N; i++) cur[i] = '0;
        cur[5] = 24'd160;
        run_frame(0, 1'b0, 1'b0, "imp_gauss");
        chk("imp_gauss_1_1", 32'(capd(5)), 32'd40);
        chk("imp_gauss_0_1", 32'(capd(1)), 32'd27);
        chk("imp_gauss_0_0", 32'(capd(0)), 32'd18);
        chk("imp_gauss_3_3", 32'(capd(15)), 32'd0);
        run_frame(1, 1'b0, 1'b0, "imp_mean");
        chk("imp_mean_1_1", 32'(capd(5)), 32'd18);
        chk("imp_mean_0_1", 32'(capd(1)), 32'd27);
        chk("imp_mean_0_0", 32'(capd(0)), 32'd40);
        chk("imp_mean_2_2", 32'(capd(10)), 32'd18);

        for (int i = 0; i < N; i++) cur[i] = {3{8'(16 * (i / W) + (i % W))}};
        run_frame(2, 1'b0, 1'b0, "ident_ramp");
        chk("ident_first_valid_after_beats", 32'(first_ov), 32'd6);
        chk("ident_pixel_2_3", 32'(capd(11)), 32'h232323);

        for (int i = 0; i < N; i++) cur[i] = 24'($urandom);
        rnd_out = 1'b1;
        run_frame(0, 1'b1, 1'b1, "random_gauss");
        rnd_out = 1'b0;

        for (int i = 0; i < N; i++) cur[i] = 24'($urandom);
        push_frame(1);
        drive_beats(7, 1, 1'b0, 1'b0, "abort");
        reset = 1'b0;
        q.delete();
        @(negedge clk);
        check_reset_vals("midframe_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) cur[i] = {3{8'd200}};
        run_frame(0, 1'b0, 1'b1, "after_reset_200");
        chk("after_reset_first", 32'(capd(0)), 32'hC8C8C8);
        chk("after_reset_last", 32'(capd(15)), 32'hC8C8C8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
